// File: rtl/sram_controller.sv
// Word-to-half-word SRAM responder for the MEM stage; ready=0 freezes the pipe.
// Optional access counters: define SRAM_ACCESS_COUNT_EN.
module sram_controller #(
  parameter int unsigned SRAM_WAIT = 2,
  parameter logic [31:0] DATA_BASE = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SRAM_ACCESS_COUNT_EN
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
`endif
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [2:0] {
    IDLE,
    WR_LO,
    WR_HI,
    RD_LO,
    RD_HI,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  wait_cnt;
  logic        last;
  logic [16:0] word_in;
  logic [16:0] word_q;
  logic [31:0] wdata_q;
  logic [15:0] rd_lo_q;
  logic        dq_oe;
  logic [15:0] dq_out;

  assign word_in = 17'((address - DATA_BASE) >> 2);
  assign last    = (wait_cnt == 3'(SRAM_WAIT - 1));
  assign ready   = !(rd_en | wr_en) | (state == DONE);

  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // next-state: write wins over read, each half held SRAM_WAIT cycles
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (wr_en)      state_nx = WR_LO;
        else if (rd_en) state_nx = RD_LO;
      end
      WR_LO:   if (last) state_nx = WR_HI;
      WR_HI:   if (last) state_nx = DONE;
      RD_LO:   if (last) state_nx = RD_HI;
      RD_HI:   if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // SRAM pin drive, decoded from state
  always_comb begin
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_ADDR = 18'd0;
    dq_oe     = 1'b0;
    dq_out    = 16'd0;
    unique case (state)
      WR_LO: begin
        SRAM_WE_N = 1'b0;
        SRAM_ADDR = {word_q, 1'b0};
        dq_oe     = 1'b1;
        dq_out    = wdata_q[15:0];
      end
      WR_HI: begin
        SRAM_WE_N = 1'b0;
        SRAM_ADDR = {word_q, 1'b1};
        dq_oe     = 1'b1;
        dq_out    = wdata_q[31:16];
      end
      RD_LO: begin
        SRAM_OE_N = 1'b0;
        SRAM_ADDR = {word_q, 1'b0};
      end
      RD_HI: begin
        SRAM_OE_N = 1'b0;
        SRAM_ADDR = {word_q, 1'b1};
      end
      default: ;
    endcase
  end

  // per-half wait counter, restarts on every state change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 3'd0;
    end else if (state == WR_LO || state == WR_HI ||
                 state == RD_LO || state == RD_HI) begin
      wait_cnt <= last ? 3'd0 : wait_cnt + 3'd1;
    end else begin
      wait_cnt <= 3'd0;
    end
  end

  // latch request operands when leaving IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q  <= 17'd0;
      wdata_q <= 32'd0;
    end else if (state == IDLE && state_nx != IDLE) begin
      word_q  <= word_in;
      wdata_q <= writeData;
    end
  end

  // capture read halves on the last cycle of each read state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_lo_q  <= 16'd0;
      readData <= 32'd0;
    end else if (last && state == RD_LO) begin
      rd_lo_q  <= SRAM_DQ;
    end else if (last && state == RD_HI) begin
      readData <= {SRAM_DQ, rd_lo_q};
    end
  end

`ifdef SRAM_ACCESS_COUNT_EN
  // completed-access counters, free-running wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (last && state == RD_HI) begin
      rd_count <= rd_count + 16'd1;
    end else if (last && state == WR_HI) begin
      wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Memory-side responder for the pipeline's MEM stage in the SRAM build.
- Accepts 32-bit word read/write requests and serialises each into two 16-bit accesses on the external asynchronous SRAM (18-bit half-word address).
- Returns the read word that feeds the WB stage's memory result.
- Drives `ready` low while busy so the pipeline freezes.

Parameters:
- SRAM_WAIT, 2, cycles each half-word access is held on the SRAM pins (1..7).
- DATA_BASE, 1024, byte address mapped to SRAM word 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rd_en  input  1  word read request (level, held while `ready`=0).
- wr_en  input  1  word write request (level, held while `ready`=0).
- address  input  32  byte address from the ALU.
- writeData  input  32  store data.
- readData  output  32  last word read, registered.
- ready  output  1  0 = freeze pipeline; 1 = idle or transaction complete.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  18  SRAM half-word address.
- SRAM_WE_N  output  1  write enable, active-low.
- SRAM_OE_N  output  1  output enable, active-low.
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  chip/byte enables, active-low; tied 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counters cleared, readData=0.
  - SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0, SRAM_DQ=Z.
  - Reset mid-transaction aborts immediately; a partially written word is left as is.
- Address mapping:
  - off = address − DATA_BASE (32-bit, wraps modulo 2^32).
  - word = off[18:2].
  - Low half: SRAM_ADDR={word,1'b0}, carries data[15:0].
  - High half: SRAM_ADDR={word,1'b1}, carries data[31:16].
  - address[1:0] are ignored.
- `ready` (combinational) = !(rd_en|wr_en) | (state==DONE).
- States:
  - IDLE: if wr_en → WR_LO; else if rd_en → RD_LO. wr_en has priority when both are asserted.
  - WR_LO / WR_HI: SRAM_WE_N=0, SRAM_OE_N=1, DQ driven with the corresponding half of writeData. Each state lasts SRAM_WAIT cycles via a wait counter, then WR_LO→WR_HI and WR_HI→DONE.
  - RD_LO / RD_HI: SRAM_WE_N=1, SRAM_OE_N=0, DQ=Z. On the last cycle of each, the corresponding DQ half is captured into an internal buffer. RD_LO→RD_HI, then RD_HI→DONE.
  - DONE: one cycle. SRAM idle (WE_N=1, OE_N=1, DQ=Z). readData already holds the assembled word (written on the RD_HI→DONE edge). Then → IDLE.
- Latency: `ready` is low for 1+2·SRAM_WAIT cycles from the first cycle a request is seen, and high in the DONE cycle. Default: 5 low, high on the 6th.
- The pipeline advances on the DONE edge. In the following IDLE cycle, a new request (the next instruction's) starts a fresh transaction. A request still asserted from the same instruction cannot occur because the pipeline has advanced.
- Requests are sampled only in IDLE. Dropping rd_en/wr_en mid-transaction does not abort it; it runs to DONE.
- readData changes only on a read's RD_HI→DONE edge. Writes leave readData unchanged.
- writeData and address are captured into registers on leaving IDLE. Later input changes have no effect on the transaction in flight.

Optional Feature:
- Macro: SRAM_ACCESS_COUNT_EN.
- When defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - Each increments on entering DONE from RD_HI or WR_HI respectively.
  - Both wrap at 16'hFFFF→0 and are cleared by rst.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst=0 mid-RD_HI → readData=0, WE_N=OE_N=1, DQ=Z, state IDLE. After rst=1 with no request, ready=1.
- Write: address=1024, writeData=32'hDEADBEEF, wr_en=1 → SRAM_ADDR=0 with DQ=16'hBEEF and WE_N=0 for 2 cycles; then SRAM_ADDR=1 with DQ=16'hDEAD for 2 cycles; ready=0 for 5 cycles, 1 on the 6th.
- Readback: after the write, rd_en=1, address=1024, SRAM model returns stored halves → readData=32'hDEADBEEF in the DONE cycle, ready=1 that cycle only.
- Mapping: address=1024+4·300+3 → SRAM_ADDR=600 then 601. address=1020 → word 17'h1FFFF, SRAM_ADDR=18'h3FFFE/18'h3FFFF.
- Simultaneous and dropped requests: rd_en=wr_en=1 → write sequence only, readData unchanged. wr_en dropped after 1 cycle → both halves still written and DONE reached.
- SRAM_ACCESS_COUNT_EN: 3 reads and 2 writes → rd_count=3, wr_count=2. Preload wr_count to FFFF via 65535 writes in a fast sim with SRAM_WAIT=1, then one more → 0.
